nios2_onchip_mem_dp: RTL and testbench
======================================

// Module: nios2_onchip_mem_dp
// PURPOSE
//  Parametrised dual-port on-chip RAM for the Nios2 system: port A is a read-only
//  Avalon-MM slave (instruction master), port B is a read/write slave with byte enables
//  (data master). It adds waitrequest/readdatavalid pipelined reads, selectable read
//  latency, an optional zero-fill after reset, and a defined mixed-port collision rule.
// PARAMETERS
//  DATA_W          32       data width; multiple of 8
//  ADDR_W          15       word address width
//  DEPTH           30720    words implemented; DEPTH <= 2**ADDR_W
//  READ_LATENCY    1        1 = unregistered q, 2 = registered q; other values illegal
//  CLEAR_ON_RESET  1        1 = zero-fill all words after reset; 0 = init from INIT_FILE only
//  INIT_FILE       "Nios2_RAM.hex"  power-up contents
// PORTS
//  clk              in   1         single clock
//  reset_n          in   1         async active-low reset
//  clken            in   1         global clock enable; low = stall
//  reset_req        in   1         high = stall (as clken low)
//  a_address        in   ADDR_W    port A word address
//  a_read           in   1         port A read request
//  a_waitrequest    out  1         port A stall
//  a_readdata       out  DATA_W    port A read data
//  a_readdatavalid  out  1         port A data valid
//  b_address        in   ADDR_W    port B word address
//  b_read           in   1         port B read request
//  b_write          in   1         port B write request
//  b_byteenable     in   DATA_W/8  port B byte lanes
//  b_writedata      in   DATA_W    port B write data
//  b_waitrequest    out  1         port B stall
//  b_readdata       out  DATA_W    port B read data
//  b_readdatavalid  out  1         port B data valid
//  init_done        out  1         high once clear FSM has finished
// BEHAVIOUR
//  Reset (reset_n low, async): FSM -> CLEAR (or RUN if CLEAR_ON_RESET=0); clear counter=0;
//   read pipelines flushed; *_readdatavalid=0, *_readdata=0, init_done=0 (1 if no clear),
//   *_waitrequest=1 while in CLEAR, else 0. Memory contents are not reset by reset_n.
//  en = clken & ~reset_req. en low: FSM, counter, pipelines hold; waitrequests forced 1.
//  FSM CLEAR: each en cycle writes 0 to word cnt, all lanes; cnt++; at cnt==DEPTH-1 the
//   write completes and FSM -> RUN next cycle, init_done=1 from that cycle. Reset mid-
//   clear restarts at 0. RUN is terminal until reset.
//  RUN: waitrequest=~en. A request is accepted when asserted with waitrequest low.
//  Read: accepted at edge N -> readdatavalid=1 with data for exactly one cycle at
//   N+READ_LATENCY; one read per port per cycle, fully pipelined, no reordering.
//  Write (B): accepted at edge N; only lanes with byteenable=1 updated; visible to any read
//   accepted at N+1 or later. No response signal.
//  b_read & b_write together: write performed, read ignored (no readdatavalid).
//  Address >= DEPTH: write dropped; read returns 0 with readdatavalid still produced.
//  B read of address being B-written same cycle: impossible (write wins above).
//  Mixed-port collision (A read, B write, same address, same cycle): see CONFIGURATION.
//  readdata holds last valid value when readdatavalid=0 (except reset -> 0).
// CONFIGURATION
//  NIOS2_RAM_MIXED_FWD_EN defined: on collision, A returns new data (written lanes from
//   b_writedata, other lanes from old word) — write-first forwarding.
//  Not defined: A returns the old word (read-before-write); no forwarding logic built.
// TESTING (DATA_W=32, DEPTH=30720 unless stated)
//  1 reset_n low 3 cycles, release, CLEAR_ON_RESET=1 -> waitrequests=1 for 30720 en
//    cycles, init_done rises next cycle; A read of 0x77FF -> 0x00000000.
//  2 RUN, B write 0x10=0xDEADBEEF be=4'b0101 over prior 0x11223344 -> B read 0x10
//    returns 0x11AD33EF, valid exactly READ_LATENCY cycles after accept (check L=1 and 2).
//  3 A and B issue back-to-back reads 0..7 every cycle -> 8 valid pulses each port,
//    in order, no gaps; toggle clken low 2 cycles mid-burst -> waitrequest=1, pipeline holds.
//  4 same cycle B write 0x20=0xCAFEF00D be=4'hF, A read 0x20 (old 0x0) -> A gets
//    0xCAFEF00D with macro, 0x00000000 without.
//  5 B write 0x7800=0x1 then A read 0x7800 -> readdatavalid=1, data 0x00000000;
//    b_read&b_write same cycle -> write occurs, no b_readdatavalid.
//  6 reset_n pulse at clear count 100 -> counter restarts at 0, init_done stays 0,
//    outstanding readdatavalid cleared asynchronously.

Source files
------------

// File: rtl/nios2_onchip_mem_dp.sv
// nios2_onchip_mem_dp: dual-port on-chip RAM for the Nios2 system.
//   Port A: read-only Avalon-MM slave (instruction master).
//   Port B: read/write Avalon-MM slave with byte enables (data master).
// Reads are pipelined with readdatavalid after READ_LATENCY (1 or 2) cycles. After reset
// an optional clear FSM zero-fills every word while both waitrequests are held high.
// Ports:
//   clk, reset_n (async, active low), clken / reset_req (global stall)
//   a_address, a_read -> a_waitrequest, a_readdata, a_readdatavalid
//   b_address, b_read, b_write, b_byteenable, b_writedata
//     -> b_waitrequest, b_readdata, b_readdatavalid
//   init_done: high once the clear FSM has finished (or straight after reset if no clear)
// Build option: define NIOS2_RAM_MIXED_FWD_EN so that an A read colliding with a B write
// to the same word returns the new data (write-first); otherwise A sees the old word.
module nios2_onchip_mem_dp #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned DEPTH          = 30720,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter string       INIT_FILE      = "Nios2_RAM.hex"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic                reset_req,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic                a_read,
  output logic                a_waitrequest,
  output logic [DATA_W-1:0]   a_readdata,
  output logic                a_readdatavalid,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [DATA_W/8-1:0] b_byteenable,
  input  logic [DATA_W-1:0]   b_writedata,
  output logic                b_waitrequest,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_readdatavalid,
  output logic                init_done
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);

  // Power-up contents come from the platform memory-init flow; the name is only carried.
  logic unused_init_file;
  assign unused_init_file = (INIT_FILE.len() > 0);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;

  logic en, run;
  assign en  = clken & ~reset_req;
  assign run = (state_q == StRun);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    if (en && (state_q == StClear)) begin
      if (cnt_q == LastWord) begin
        state_d     = StRun;
        init_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CLEAR_ON_RESET ? StClear : StRun;
      cnt_q       <= '0;
      init_done_q <= ~CLEAR_ON_RESET;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_done     = init_done_q;
  assign a_waitrequest = ~(run & en);
  assign b_waitrequest = ~(run & en);

  // Request acceptance; a combined B read+write is treated as a write only.
  logic a_acc, b_rd_acc, b_wr_acc, a_in_range, b_in_range, b_we, clr_we;
  assign a_acc      = a_read & run & en;
  assign b_wr_acc   = b_write & run & en;
  assign b_rd_acc   = b_read & ~b_write & run & en;
  assign a_in_range = ({1'b0, a_address} < DepthW);
  assign b_in_range = ({1'b0, b_address} < DepthW);
  assign b_we       = b_wr_acc & b_in_range;
  assign clr_we     = en & (state_q == StClear);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q[IdxW-1:0]] <= '0;
    end else if (b_we) begin
      for (int unsigned i = 0; i < BeW; i++) begin
        if (b_byteenable[i]) mem[b_address[IdxW-1:0]][8*i +: 8] <= b_writedata[8*i +: 8];
      end
    end
  end

  // Array reads are sampled at the same edge the write lands, so they see the old word.
  logic [DATA_W-1:0] a_rd_raw, a_rd_data, b_rd_data;
  assign a_rd_raw  = a_in_range ? mem[a_address[IdxW-1:0]] : '0;
  assign b_rd_data = b_in_range ? mem[b_address[IdxW-1:0]] : '0;

`ifdef NIOS2_RAM_MIXED_FWD_EN
  always_comb begin
    a_rd_data = a_rd_raw;
    if (b_we && (b_address == a_address)) begin
      for (int unsigned i = 0; i < BeW; i++) begin
        if (b_byteenable[i]) a_rd_data[8*i +: 8] = b_writedata[8*i +: 8];
      end
    end
  end
`else
  assign a_rd_data = a_rd_raw;
`endif

  // First read stage; everything holds while en is low.
  logic              a_v1_q, a_v1_d, b_v1_q, b_v1_d;
  logic [DATA_W-1:0] a_d1_q, a_d1_d, b_d1_q, b_d1_d;

  always_comb begin
    a_v1_d = en ? a_acc : a_v1_q;
    b_v1_d = en ? b_rd_acc : b_v1_q;
    a_d1_d = a_acc ? a_rd_data : a_d1_q;
    b_d1_d = b_rd_acc ? b_rd_data : b_d1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_v1_q <= 1'b0;
      b_v1_q <= 1'b0;
      a_d1_q <= '0;
      b_d1_q <= '0;
    end else begin
      a_v1_q <= a_v1_d;
      b_v1_q <= b_v1_d;
      a_d1_q <= a_d1_d;
      b_d1_q <= b_d1_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic              a_v2_q, a_v2_d, b_v2_q, b_v2_d;
    logic [DATA_W-1:0] a_d2_q, a_d2_d, b_d2_q, b_d2_d;

    always_comb begin
      a_v2_d = en ? a_v1_q : a_v2_q;
      b_v2_d = en ? b_v1_q : b_v2_q;
      a_d2_d = (en && a_v1_q) ? a_d1_q : a_d2_q;
      b_d2_d = (en && b_v1_q) ? b_d1_q : b_d2_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        a_v2_q <= 1'b0;
        b_v2_q <= 1'b0;
        a_d2_q <= '0;
        b_d2_q <= '0;
      end else begin
        a_v2_q <= a_v2_d;
        b_v2_q <= b_v2_d;
        a_d2_q <= a_d2_d;
        b_d2_q <= b_d2_d;
      end
    end

    assign a_readdatavalid = a_v2_q;
    assign a_readdata      = a_d2_q;
    assign b_readdatavalid = b_v2_q;
    assign b_readdata      = b_d2_q;
  end else begin : g_lat1
    // Any value other than 2 builds the single-stage pipeline.
    assign a_readdatavalid = a_v1_q;
    assign a_readdata      = a_d1_q;
    assign b_readdatavalid = b_v1_q;
    assign b_readdata      = b_d1_q;
  end

endmodule

// File: tb/tb_nios2_onchip_mem_dp.sv
// Directed bench for nios2_onchip_mem_dp: main instance (latency 1, clear on reset) and a
// small latency-2 instance without clear for the registered-output path.
module tb_nios2_onchip_mem_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, clken, reset_req;
  logic [14:0] a_address, b_address;
  logic        a_read, b_read, b_write;
  logic [3:0]  b_byteenable;
  logic [31:0] b_writedata, a_readdata, b_readdata;
  logic        a_waitrequest, a_readdatavalid, b_waitrequest, b_readdatavalid, init_done;

  logic [14:0] l2_a_address, l2_b_address;
  logic        l2_a_read, l2_b_read, l2_b_write;
  logic [3:0]  l2_b_byteenable;
  logic [31:0] l2_b_writedata, l2_a_readdata, l2_b_readdata;
  logic        l2_a_waitrequest, l2_a_readdatavalid, l2_b_waitrequest, l2_b_readdatavalid;
  logic        l2_init_done;

  nios2_onchip_mem_dp u_dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .clken           (clken),
    .reset_req       (reset_req),
    .a_address       (a_address),
    .a_read          (a_read),
    .a_waitrequest   (a_waitrequest),
    .a_readdata      (a_readdata),
    .a_readdatavalid (a_readdatavalid),
    .b_address       (b_address),
    .b_read          (b_read),
    .b_write         (b_write),
    .b_byteenable    (b_byteenable),
    .b_writedata     (b_writedata),
    .b_waitrequest   (b_waitrequest),
    .b_readdata      (b_readdata),
    .b_readdatavalid (b_readdatavalid),
    .init_done       (init_done)
  );

  nios2_onchip_mem_dp #(
    .DEPTH          (256),
    .READ_LATENCY   (2),
    .CLEAR_ON_RESET (1'b0)
  ) u_dut_l2 (
    .clk             (clk),
    .reset_n         (reset_n),
    .clken           (clken),
    .reset_req       (reset_req),
    .a_address       (l2_a_address),
    .a_read          (l2_a_read),
    .a_waitrequest   (l2_a_waitrequest),
    .a_readdata      (l2_a_readdata),
    .a_readdatavalid (l2_a_readdatavalid),
    .b_address       (l2_b_address),
    .b_read          (l2_b_read),
    .b_write         (l2_b_write),
    .b_byteenable    (l2_b_byteenable),
    .b_writedata     (l2_b_writedata),
    .b_waitrequest   (l2_b_waitrequest),
    .b_readdata      (l2_b_readdata),
    .b_readdatavalid (l2_b_readdatavalid),
    .init_done       (l2_init_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All helpers start and end at a falling edge.
  task automatic b_write_op(input logic [14:0] addr, input logic [31:0] data,
                            input logic [3:0] be);
    b_address = addr; b_writedata = data; b_byteenable = be; b_write = 1'b1;
    @(negedge clk);
    b_write = 1'b0;
  endtask

  task automatic a_read_chk(input string tag, input logic [14:0] addr, input logic [31:0] exp);
    a_address = addr; a_read = 1'b1;
    @(negedge clk);
    a_read = 1'b0;
    check_eq({tag, "_valid"}, 32'(a_readdatavalid), 32'd1);
    check_eq({tag, "_data"}, a_readdata, exp);
    @(negedge clk);
    check_eq({tag, "_valid_drop"}, 32'(a_readdatavalid), 32'd0);
    check_eq({tag, "_data_hold"}, a_readdata, exp);
  endtask

  task automatic b_read_chk(input string tag, input logic [14:0] addr, input logic [31:0] exp);
    b_address = addr; b_read = 1'b1;
    @(negedge clk);
    b_read = 1'b0;
    check_eq({tag, "_valid"}, 32'(b_readdatavalid), 32'd1);
    check_eq({tag, "_data"}, b_readdata, exp);
    @(negedge clk);
    check_eq({tag, "_valid_drop"}, 32'(b_readdatavalid), 32'd0);
  endtask

  task automatic wait_clear(input string tag, input int exp_cycles, input int stall_cycles);
    int cyc;
    int early;
    cyc = 0;
    early = 0;
    while (a_waitrequest && cyc < 40000) begin
      if (init_done) early++;
      @(negedge clk);
      cyc++;
      if (cyc == stall_cycles) reset_req = 1'b0;
    end
    check_eq({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
    check_eq({tag, "_early_done"}, 32'(early), 32'd0);
    check_eq({tag, "_init_done"}, 32'(init_done), 32'd1);
    check_eq({tag, "_b_wait"}, 32'(b_waitrequest), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  logic [31:0] words [8];
  int          sched [12];
  logic [31:0] exp_fwd;
  logic [31:0] exp_part;

  initial begin
    reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
    a_address = '0; a_read = 1'b0;
    b_address = '0; b_read = 1'b0; b_write = 1'b0; b_byteenable = '0; b_writedata = '0;
    l2_a_address = '0; l2_a_read = 1'b0;
    l2_b_address = '0; l2_b_read = 1'b0; l2_b_write = 1'b0;
    l2_b_byteenable = '0; l2_b_writedata = '0;

    // 1: reset values, full clear, last word reads back zero
    repeat (3) @(negedge clk);
    check_eq("rst_a_wait", 32'(a_waitrequest), 32'd1);
    check_eq("rst_b_wait", 32'(b_waitrequest), 32'd1);
    check_eq("rst_init_done", 32'(init_done), 32'd0);
    check_eq("rst_a_valid", 32'(a_readdatavalid), 32'd0);
    check_eq("rst_a_data", a_readdata, 32'd0);
    check_eq("rst_b_data", b_readdata, 32'd0);
    check_eq("rst_l2_init_done", 32'(l2_init_done), 32'd1);
    check_eq("rst_l2_wait", 32'(l2_a_waitrequest), 32'd0);
    reset_n = 1'b1;
    wait_clear("clr1", 30720, 0);
    a_read_chk("clr1_last", 15'h77FF, 32'h0);

    // 2: byte-lane merge, latency 1 and latency 2
    b_write_op(15'h10, 32'h11223344, 4'hF);
    b_write_op(15'h10, 32'hDEADBEEF, 4'b0101);
    b_read_chk("be_l1_b", 15'h10, 32'h11AD33EF);
    a_read_chk("be_l1_a", 15'h10, 32'h11AD33EF);

    l2_b_address = 15'h10; l2_b_byteenable = 4'hF; l2_b_writedata = 32'h11223344;
    l2_b_write = 1'b1;
    @(negedge clk);
    l2_b_byteenable = 4'b0101; l2_b_writedata = 32'hDEADBEEF;
    @(negedge clk);
    l2_b_write = 1'b0; l2_b_read = 1'b1; l2_a_read = 1'b1; l2_a_address = 15'h10;
    @(negedge clk);
    l2_b_read = 1'b0; l2_a_read = 1'b0;
    check_eq("be_l2_early_valid", 32'(l2_b_readdatavalid), 32'd0);
    @(negedge clk);
    check_eq("be_l2_b_valid", 32'(l2_b_readdatavalid), 32'd1);
    check_eq("be_l2_b_data", l2_b_readdata, 32'h11AD33EF);
    check_eq("be_l2_a_valid", 32'(l2_a_readdatavalid), 32'd1);
    check_eq("be_l2_a_data", l2_a_readdata, 32'h11AD33EF);
    @(negedge clk);
    check_eq("be_l2_b_valid_drop", 32'(l2_b_readdatavalid), 32'd0);
    check_eq("be_l2_b_data_hold", l2_b_readdata, 32'h11AD33EF);

    // 3: back-to-back reads with a two-cycle stall in the middle
    for (int i = 0; i < 8; i++) begin
      words[i] = 32'hA5000000 + 32'(i) * 32'h01010101;
      b_write_op(15'(i), words[i], 4'hF);
    end
    sched = '{0, 1, 2, 3, -1, -1, 4, 5, 6, 7, -2, -2};
    begin
      int na;
      int nb;
      na = 0;
      nb = 0;
      for (int c = 0; c < 12; c++) begin
        clken = (sched[c] != -1);
        a_read = (sched[c] != -2);
        b_read = (sched[c] != -2);
        a_address = (sched[c] >= 0) ? 15'(sched[c]) : 15'd4;
        b_address = a_address;
        @(negedge clk);
        if (sched[c] == -1) begin
          check_eq("burst_stall_a_wait", 32'(a_waitrequest), 32'd1);
          check_eq("burst_stall_b_wait", 32'(b_waitrequest), 32'd1);
          check_eq("burst_stall_a_hold", a_readdata, words[3]);
          check_eq("burst_stall_a_vhold", 32'(a_readdatavalid), 32'd1);
        end else begin
          check_eq("burst_a_valid", 32'(a_readdatavalid), 32'(sched[c] >= 0));
          check_eq("burst_b_valid", 32'(b_readdatavalid), 32'(sched[c] >= 0));
          if (a_readdatavalid && na < 8) begin
            check_eq("burst_a_data", a_readdata, words[na]);
            na++;
          end
          if (b_readdatavalid && nb < 8) begin
            check_eq("burst_b_data", b_readdata, words[nb]);
            nb++;
          end
        end
      end
      check_eq("burst_a_beats", 32'(na), 32'd8);
      check_eq("burst_b_beats", 32'(nb), 32'd8);
      clken = 1'b1; a_read = 1'b0; b_read = 1'b0;
    end

    // 4: mixed-port collision, full word then partial lanes
`ifdef NIOS2_RAM_MIXED_FWD_EN
    exp_fwd  = 32'hCAFEF00D;
    exp_part = 32'hCAFE2222;
`else
    exp_fwd  = 32'h00000000;
    exp_part = 32'hCAFEF00D;
`endif
    a_address = 15'h20; a_read = 1'b1;
    b_write_op(15'h20, 32'hCAFEF00D, 4'hF);
    a_read = 1'b0;
    check_eq("coll_full_valid", 32'(a_readdatavalid), 32'd1);
    check_eq("coll_full_data", a_readdata, exp_fwd);
    a_address = 15'h20; a_read = 1'b1;
    b_write_op(15'h20, 32'h11112222, 4'b0011);
    a_read = 1'b0;
    check_eq("coll_part_data", a_readdata, exp_part);
    @(negedge clk);
    a_read_chk("coll_after", 15'h20, 32'hCAFE2222);

    // 5: out-of-range accesses, combined read+write, last-word write
    b_write_op(15'h7800, 32'h1, 4'hF);
    a_read_chk("oor_a", 15'h7800, 32'h0);
    b_read_chk("oor_b", 15'h7800, 32'h0);
    b_address = 15'h30; b_writedata = 32'h12345678; b_byteenable = 4'hF;
    b_read = 1'b1; b_write = 1'b1;
    @(negedge clk);
    b_read = 1'b0; b_write = 1'b0;
    check_eq("rw_no_valid", 32'(b_readdatavalid), 32'd0);
    b_read_chk("rw_written", 15'h30, 32'h12345678);
    b_write_op(15'h77FF, 32'hFFFFFFFF, 4'hF);
    a_read_chk("last_word", 15'h77FF, 32'hFFFFFFFF);

    // 6: async reset flushes outstanding reads; reset mid-clear restarts the count
    a_address = 15'h10; a_read = 1'b1; b_address = 15'h30; b_read = 1'b1;
    @(posedge clk);
    #2;
    a_read = 1'b0; b_read = 1'b0;
    check_eq("flush_pre_valid", 32'(a_readdatavalid), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("flush_a_valid", 32'(a_readdatavalid), 32'd0);
    check_eq("flush_b_valid", 32'(b_readdatavalid), 32'd0);
    check_eq("flush_a_data", a_readdata, 32'h0);
    check_eq("flush_init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    check_eq("mid_clr_wait", 32'(a_waitrequest), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("mid_clr_init_done", 32'(init_done), 32'd0);
    check_eq("mid_clr_b_wait", 32'(b_waitrequest), 32'd1);
    reset_n = 1'b1;
    reset_req = 1'b1;
    wait_clear("clr2", 30725, 5);
    a_read_chk("clr2_w10", 15'h10, 32'h0);
    a_read_chk("clr2_last", 15'h77FF, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
